// File: rtl/hazard_sched_ctrl.sv
// Pipeline sequencer for the 5-stage datapath: stage hold/bubble/flush enables, ALU forwarding
// selects, data-memory freeze with watchdog, and saturating stall/flush counters.
module hazard_sched_ctrl #(
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned MAX_WAIT       = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       idex_dest,
  input  logic             idex_mem_read,
  input  logic [4:0]       exmem_dest,
  input  logic [1:0]       exmem_wb,
  input  logic [4:0]       memwb_dest,
  input  logic [1:0]       memwb_wb,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned RemW       = (BRANCH_PENALTY > 2) ? $clog2(BRANCH_PENALTY) : 1;
  localparam int unsigned WaitW      = $clog2(MAX_WAIT + 1);
  localparam bit          MultiFlush = (BRANCH_PENALTY > 1);

  typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

  state_e           state_q, state_d, ret_q, ret_d;
  logic [RemW-1:0]  rem_q, rem_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic freeze, load_use;
  logic unused_memtoreg;

  // MemtoReg bits only steer the writeback mux, not forwarding.
  assign unused_memtoreg = exmem_wb[0] ^ memwb_wb[0];

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = idex_mem_read & (idex_dest != 5'd0) &
                    ((idex_dest == ifid_rs) | (idex_dest == ifid_rt));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StRun;
      ret_q     <= StRun;
      rem_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    rem_d     = rem_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (freeze) begin
      state_d = StMemWait;
      // Remember where to resume only on entry; repeated freezes keep the original target.
      if (state_q != StMemWait) ret_d = state_q;
      wait_d = (wait_q == WaitW'(MAX_WAIT)) ? wait_q : wait_q + WaitW'(1);
      if (wait_q >= WaitW'(MAX_WAIT - 1)) timeout_d = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_taken && MultiFlush) begin
            state_d = StFlush;
            rem_d   = RemW'(BRANCH_PENALTY - 1);
          end
        end
        StMemWait: state_d = ret_q;
        StFlush: begin
          rem_d = rem_q - RemW'(1);
          if (rem_q <= RemW'(1)) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!reset) begin
      if (exmem_wb[1] && (exmem_dest != 5'd0) && (exmem_dest == idex_rs)) fwd_a = 2'b10;
      else if (memwb_wb[1] && (memwb_dest != 5'd0) && (memwb_dest == idex_rs)) fwd_a = 2'b01;
      if (exmem_wb[1] && (exmem_dest != 5'd0) && (exmem_dest == idex_rt)) fwd_b = 2'b10;
      else if (memwb_wb[1] && (memwb_dest != 5'd0) && (memwb_dest == idex_rt)) fwd_b = 2'b01;

      if (freeze) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        pipe_freeze = 1'b1;
      end else begin
        unique case (state_q)
          StRun: begin
            if (branch_taken) begin
              ifid_flush  = 1'b1;
              idex_bubble = 1'b1;
            end else if (load_use) begin
              pc_write    = 1'b0;
              ifid_write  = 1'b0;
              idex_bubble = 1'b1;
            end
          end
          StFlush: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Scoreboard bench for hazard_sched_ctrl: stimulus pushes expected per-cycle outputs, a negedge
// monitor pops and compares them.
module tb_hazard_sched_ctrl;

  localparam logic [4:0] Idle = 5'b11000;  // {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
  localparam logic [4:0] Frz  = 5'b00001;
  localparam logic [4:0] Fls  = 5'b11110;
  localparam logic [4:0] Ldu  = 5'b00010;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_dest, exmem_dest, memwb_dest;
  logic       idex_mem_read, mem_req, mem_ready, branch_taken;
  logic [1:0] exmem_wb, memwb_wb;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cnt, flush_cnt;

  hazard_sched_ctrl #(.BRANCH_PENALTY(2), .MAX_WAIT(64), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_dest(idex_dest), .idex_mem_read(idex_mem_read),
    .exmem_dest(exmem_dest), .exmem_wb(exmem_wb), .memwb_dest(memwb_dest), .memwb_wb(memwb_wb),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       to;
    logic [3:0] sc;
    logic [3:0] fc;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_stall, m_flush;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, " ctrl"}, int'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}),
          int'(e.ctrl));
      chk({e.name, " fwd_a"}, int'(fwd_a), int'(e.fa));
      chk({e.name, " fwd_b"}, int'(fwd_b), int'(e.fb));
      chk({e.name, " mem_timeout"}, int'(mem_timeout), int'(e.to));
      chk({e.name, " stall_cnt"}, int'(stall_cnt), int'(e.sc));
      chk({e.name, " flush_cnt"}, int'(flush_cnt), int'(e.fc));
    end
  end

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0; idex_dest = 5'd0;
    exmem_dest = 5'd0; memwb_dest = 5'd0; exmem_wb = 2'b00; memwb_wb = 2'b00;
    idex_mem_read = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  // Push expected outputs for the current cycle, update the counter model, advance a cycle.
  task automatic cyc(input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic to, input string name);
    exp_t e;
    e.ctrl = ctrl; e.fa = fa; e.fb = fb; e.to = to;
    e.sc = m_stall; e.fc = m_flush; e.name = name;
    sb.push_back(e);
    if (reset) begin
      m_stall = 4'd0;
      m_flush = 4'd0;
    end else begin
      if (!ctrl[4] && m_stall != 4'hf) m_stall = m_stall + 4'd1;
      if (ctrl[2] && m_flush != 4'hf) m_flush = m_flush + 4'd1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    m_stall = 4'd0;
    m_flush = 4'd0;

    cyc(Idle, 2'b00, 2'b00, 1'b0, "reset_state");

    // Load-use
    idex_mem_read = 1'b1; idex_dest = 5'd5; ifid_rs = 5'd5;
    cyc(Ldu, 2'b00, 2'b00, 1'b0, "loaduse_rs");
    idle_inputs();
    cyc(Idle, 2'b00, 2'b00, 1'b0, "after_loaduse");
    idex_mem_read = 1'b1; idex_dest = 5'd0;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "loaduse_r0");
    idex_dest = 5'd7; ifid_rt = 5'd7;
    cyc(Ldu, 2'b00, 2'b00, 1'b0, "loaduse_rt");
    idle_inputs();

    // Forwarding
    exmem_dest = 5'd3; memwb_dest = 5'd3; exmem_wb = 2'b10; memwb_wb = 2'b10;
    idex_rs = 5'd3; idex_rt = 5'd9;
    cyc(Idle, 2'b10, 2'b00, 1'b0, "fwd_double");
    exmem_wb = 2'b01;
    cyc(Idle, 2'b01, 2'b00, 1'b0, "fwd_memwb");
    exmem_wb = 2'b11; exmem_dest = 5'd9; idex_rt = 5'd9;
    cyc(Idle, 2'b01, 2'b10, 1'b0, "fwd_split");
    exmem_dest = 5'd0; memwb_dest = 5'd0; idex_rs = 5'd0; idex_rt = 5'd0;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "fwd_r0");
    memwb_dest = 5'd4; memwb_wb = 2'b01; idex_rs = 5'd4;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "fwd_noregwrite");
    idle_inputs();

    // Branch with a load-use hazard present in the same cycle, held into FLUSH
    branch_taken = 1'b1; idex_mem_read = 1'b1; idex_dest = 5'd6; ifid_rs = 5'd6;
    cyc(Fls, 2'b00, 2'b00, 1'b0, "branch_c0");
    idex_mem_read = 1'b0;
    cyc(Fls, 2'b00, 2'b00, 1'b0, "branch_c1");
    idle_inputs();
    cyc(Idle, 2'b00, 2'b00, 1'b0, "branch_done");

    // Memory freeze
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc(Frz, 2'b00, 2'b00, 1'b0, "freeze5");
    mem_ready = 1'b1;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "freeze_ready");
    idle_inputs();
    cyc(Idle, 2'b00, 2'b00, 1'b0, "freeze_done");

    // Freeze in the middle of a flush sequence
    branch_taken = 1'b1;
    cyc(Fls, 2'b00, 2'b00, 1'b0, "midflush_br");
    branch_taken = 1'b0; mem_req = 1'b1;
    cyc(Frz, 2'b00, 2'b00, 1'b0, "midflush_frz");
    mem_ready = 1'b1;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "midflush_ready");
    idle_inputs();
    cyc(Fls, 2'b00, 2'b00, 1'b0, "midflush_resume");
    cyc(Idle, 2'b00, 2'b00, 1'b0, "midflush_done");

    // Watchdog
    mem_req = 1'b1;
    for (int i = 0; i < 64; i++) cyc(Frz, 2'b00, 2'b00, 1'b0, "wd_wait");
    mem_ready = 1'b1;
    cyc(Idle, 2'b00, 2'b00, 1'b1, "wd_set");
    idle_inputs();
    cyc(Idle, 2'b00, 2'b00, 1'b1, "wd_sticky");
    reset = 1'b1;
    cyc(Idle, 2'b00, 2'b00, 1'b1, "wd_in_reset");
    reset = 1'b0;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "wd_cleared");

    // Reset while waiting on memory
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc(Frz, 2'b00, 2'b00, 1'b0, "rst_wait");
    reset = 1'b1;
    exmem_dest = 5'd2; exmem_wb = 2'b10; idex_rs = 5'd2;
    cyc(Idle, 2'b00, 2'b00, 1'b0, "rst_during_wait");
    reset = 1'b0;
    idle_inputs();
    cyc(Idle, 2'b00, 2'b00, 1'b0, "rst_after");
    branch_taken = 1'b1;
    cyc(Fls, 2'b00, 2'b00, 1'b0, "rst_run_br");
    branch_taken = 1'b0;
    cyc(Fls, 2'b00, 2'b00, 1'b0, "rst_run_fl");
    cyc(Idle, 2'b00, 2'b00, 1'b0, "rst_run_done");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
